obb_step_scheduler: RTL
=======================

# obb_step_scheduler

Sequences the per-frame physics step for the two oriented bounding boxes that feed the pixel color mapper and collision detector. On each frame edge it runs a fixed sequence: integrate OBB1, integrate OBB2, wait for the collision detector to settle, and resolve if colliding. It then commits the new state and flips the display buffer, so the renderer only ever sees a fully updated state pair. It owns no arithmetic; it drives start/done handshakes to the external integrator and resolver datapaths.

## Interface
- SUBSTEPS, default 1: physics substeps per frame, range 1–15.
- DETECT_CYCLES, default 4: settle cycles allowed for the combinational collision path, range 1–15.
- WD_LIMIT, default 1023: watchdog cycle limit per wait state; used only under PHYS_WATCHDOG_EN.
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- vsync  in  1  frame marker, already in the Clk domain; rising edge = frame start.
- pause  in  1  level; while high, frame edges are ignored and not counted as overruns.
- is_collision  in  1  collision detector output.
- integ_done  in  1  one-cycle pulse from the integrator.
- res_done  in  1  one-cycle pulse from the resolver.
- integ_start  out  1  one-cycle pulse starting the integrator.
- integ_sel  out  1  integrator target: 0 = OBB1, 1 = OBB2; stable from integ_start until integ_done.
- res_start  out  1  one-cycle pulse starting the resolver.
- commit  out  1  one-cycle pulse; the datapath latches working state into the back buffer.
- disp_buf_sel  out  1  display buffer index; toggles once per completed frame.
- busy  out  1  high in every state except IDLE.
- collision_seen  out  1  sticky within a frame; cleared at the next frame start.
- overrun_cnt  out  8  count of frame edges arriving while busy; saturates at 255.
- frame_cnt  out  16  count of completed frames; wraps.
- wd_fault  out  1  sticky watchdog flag.

## Operation
- States: IDLE, INTEG1, INTEG2, DETECT, RESOLVE, COMMIT.
- Frame edge: `vsync & ~vsync_q`, using a one-cycle registered copy of vsync.
- IDLE:
  - On a frame edge with pause low: go to INTEG1, pulse integ_start with integ_sel=0, clear collision_seen, load substep_cnt=0.
- INTEG1:
  - On integ_done: go to INTEG2, pulse integ_start with integ_sel=1.
- INTEG2:
  - On integ_done: go to DETECT, load settle_cnt=DETECT_CYCLES-1.
- DETECT:
  - Decrement settle_cnt each cycle.
  - At settle_cnt==0, sample is_collision.
  - If set: set collision_seen, pulse res_start, go to RESOLVE.
  - Otherwise: go to COMMIT.
- RESOLVE:
  - On res_done: go to COMMIT.
- COMMIT:
  - Pulse commit.
  - If substep_cnt < SUBSTEPS-1: increment substep_cnt, go to INTEG1 and pulse integ_start with integ_sel=0.
  - Otherwise: toggle disp_buf_sel, increment frame_cnt, go to IDLE.
- Frame edge in any non-IDLE state: increment overrun_cnt (saturating); the edge is dropped, not queued.
- Done pulses arriving in a state that is not waiting for them are ignored.
- Reset:
  - All outputs 0; state IDLE; vsync_q = 0.
  - Reset mid-operation aborts with no commit pulse.
  - The datapath is responsible for discarding partial working state.

## Timing
- Frame edge sampled at cycle t gives integ_start at t+1, i.e. the first cycle in INTEG1 (registered output).
- integ_done at cycle u gives the next state and pulse at u+1. Same rule for res_done.
- Collision-free frame, SUBSTEPS=1, integrator latency L each: commit pulses 2L + DETECT_CYCLES + 3 cycles after the edge.
- disp_buf_sel and frame_cnt update on the cycle after the final commit pulse. busy drops on that same cycle.
- A frame edge arriving on the cycle busy drops is accepted: the FSM is in IDLE at that point.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- PHYS_WATCHDOG_EN defined:
  - A wd_cnt counter resets on every state entry and increments in INTEG1, INTEG2 and RESOLVE.
  - When wd_cnt reaches WD_LIMIT: set wd_fault, go to IDLE, no commit, no buffer toggle.
  - wd_fault clears only on Reset.
- PHYS_WATCHDOG_EN undefined:
  - Wait states block indefinitely.
  - wd_fault is tied to 0 and WD_LIMIT is unused.

## Structure
- Shared package phys_pkg holds:
  - the sched_state_t enum (IDLE..COMMIT);
  - SUBSTEP_W and SETTLE_W width constants;
  - the OBB_SEL_1 / OBB_SEL_2 encodings.
- One sub-module, step_watchdog, wraps the counter, limit compare and sticky fault. It is instantiated only under PHYS_WATCHDOG_EN.

## Test plan
- Nominal frame (SUBSTEPS=1, DETECT_CYCLES=4, integ_done 5 cycles after each start, is_collision=0, edge at cycle 10):
  - integ_start at 11 (sel=0) and 17 (sel=1);
  - commit at 27; disp_buf_sel=1 and frame_cnt=1 at 28.
- Collision path (is_collision=1 during DETECT, res_done 3 cycles after res_start):
  - exactly one res_start;
  - commit follows res_done by 1 cycle;
  - collision_seen=1 until the next frame edge.
- Overrun (three vsync edges while busy, then 300 more edges while busy):
  - overrun_cnt=3 after the first three, then 255 saturated;
  - only one commit per accepted frame.
- Substeps (SUBSTEPS=3):
  - six integ_start pulses with sel pattern 0,1,0,1,0,1;
  - three commit pulses; disp_buf_sel toggles once.
- Reset mid-INTEG2:
  - next cycle: state IDLE, every output 0, no commit;
  - the following frame edge runs normally.
- PHYS_WATCHDOG_EN defined, WD_LIMIT=1023, integ_done never asserted:
  - wd_fault=1 at 1023 cycles after INTEG1 entry;
  - busy=0; frame_cnt unchanged.

Source files
------------

// File: rtl/phys_pkg.sv
// rtl/phys_pkg.sv - shared states, widths and OBB select encodings for the step scheduler
package phys_pkg;

  localparam int SUBSTEP_W = 4;
  localparam int SETTLE_W  = 4;

  localparam logic OBB_SEL_1 = 1'b0;
  localparam logic OBB_SEL_2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INTEG1  = 3'd1,
    INTEG2  = 3'd2,
    DETECT  = 3'd3,
    RESOLVE = 3'd4,
    COMMIT  = 3'd5
  } sched_state_t;

endpackage

// File: rtl/step_watchdog.sv
// rtl/step_watchdog.sv - wait-state cycle counter with sticky fault, built only with PHYS_WATCHDOG_EN
`ifdef PHYS_WATCHDOG_EN
module step_watchdog #(
  parameter int WD_LIMIT = 1023
) (
  input  logic Clk,
  input  logic Reset,
  input  logic restart,
  input  logic count_en,
  output logic expire,
  output logic fault
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt;

  // Fires on the cycle whose increment would bring the count to the limit.
  assign expire = count_en && (wd_cnt == WD_W'(WD_LIMIT - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wd_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      if (restart) begin
        wd_cnt <= '0;
      end else if (count_en) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (expire) begin
        fault <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/obb_step_scheduler.sv
// rtl/obb_step_scheduler.sv - per-frame OBB integrate/detect/resolve/commit sequencer
// Optional watchdog on wait states is enabled by defining PHYS_WATCHDOG_EN.
module obb_step_scheduler
  import phys_pkg::*;
#(
  parameter int SUBSTEPS      = 1,
  parameter int DETECT_CYCLES = 4,
  parameter int WD_LIMIT      = 1023
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vsync,
  input  logic        pause,
  input  logic        is_collision,
  input  logic        integ_done,
  input  logic        res_done,
  output logic        integ_start,
  output logic        integ_sel,
  output logic        res_start,
  output logic        commit,
  output logic        disp_buf_sel,
  output logic        busy,
  output logic        collision_seen,
  output logic [7:0]  overrun_cnt,
  output logic [15:0] frame_cnt,
  output logic        wd_fault
);

  if (SUBSTEPS < 1 || SUBSTEPS > 15) begin : g_bad_substeps
    $error("SUBSTEPS out of range 1..15");
  end
  if (DETECT_CYCLES < 1 || DETECT_CYCLES > 15) begin : g_bad_detect
    $error("DETECT_CYCLES out of range 1..15");
  end
  if (WD_LIMIT < 1) begin : g_bad_wd_limit
    $error("WD_LIMIT must be positive");
  end

  sched_state_t        state, state_n;
  logic                vsync_q;
  logic [SUBSTEP_W-1:0] substep_cnt, substep_n;
  logic [SETTLE_W-1:0]  settle_cnt, settle_n;
  logic                integ_start_n, integ_sel_n, res_start_n, commit_n;
  logic                coll_n, disp_n;
  logic [7:0]          overrun_n;
  logic [15:0]         frame_n;
  logic                frame_edge;
  logic                wd_expire;

  assign frame_edge = vsync & ~vsync_q;
  assign busy       = (state != IDLE);

`ifdef PHYS_WATCHDOG_EN
  step_watchdog #(
    .WD_LIMIT (WD_LIMIT)
  ) u_step_watchdog (
    .Clk      (Clk),
    .Reset    (Reset),
    .restart  (state_n != state),
    .count_en (state == INTEG1 || state == INTEG2 || state == RESOLVE),
    .expire   (wd_expire),
    .fault    (wd_fault)
  );
`else
  assign wd_expire = 1'b0;
  assign wd_fault  = 1'b0;
`endif

  always_comb begin
    state_n       = state;
    integ_start_n = 1'b0;
    integ_sel_n   = integ_sel;
    res_start_n   = 1'b0;
    commit_n      = 1'b0;
    substep_n     = substep_cnt;
    settle_n      = settle_cnt;
    coll_n        = collision_seen;
    disp_n        = disp_buf_sel;
    frame_n       = frame_cnt;
    overrun_n     = overrun_cnt;

    // Edges while busy are dropped, only counted.
    if (frame_edge && !pause && state != IDLE && overrun_cnt != 8'hFF) begin
      overrun_n = overrun_cnt + 8'd1;
    end

    case (state)
      IDLE: begin
        if (frame_edge && !pause) begin
          state_n       = INTEG1;
          integ_start_n = 1'b1;
          integ_sel_n   = OBB_SEL_1;
          coll_n        = 1'b0;
          substep_n     = '0;
        end
      end
      INTEG1: begin
        if (integ_done) begin
          state_n       = INTEG2;
          integ_start_n = 1'b1;
          integ_sel_n   = OBB_SEL_2;
        end
      end
      INTEG2: begin
        if (integ_done) begin
          state_n  = DETECT;
          settle_n = SETTLE_W'(DETECT_CYCLES - 1);
        end
      end
      DETECT: begin
        if (settle_cnt == '0) begin
          if (is_collision) begin
            state_n     = RESOLVE;
            coll_n      = 1'b1;
            res_start_n = 1'b1;
          end else begin
            state_n  = COMMIT;
            commit_n = 1'b1;
          end
        end else begin
          settle_n = settle_cnt - SETTLE_W'(1);
        end
      end
      RESOLVE: begin
        if (res_done) begin
          state_n  = COMMIT;
          commit_n = 1'b1;
        end
      end
      COMMIT: begin
        if (substep_cnt < SUBSTEP_W'(SUBSTEPS - 1)) begin
          state_n       = INTEG1;
          substep_n     = substep_cnt + SUBSTEP_W'(1);
          integ_start_n = 1'b1;
          integ_sel_n   = OBB_SEL_1;
        end else begin
          state_n = IDLE;
          disp_n  = ~disp_buf_sel;
          frame_n = frame_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A stuck wait state is abandoned without commit or buffer flip.
    if (wd_expire) begin
      state_n       = IDLE;
      integ_start_n = 1'b0;
      res_start_n   = 1'b0;
      commit_n      = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      vsync_q        <= 1'b0;
      substep_cnt    <= '0;
      settle_cnt     <= '0;
      integ_start    <= 1'b0;
      integ_sel      <= 1'b0;
      res_start      <= 1'b0;
      commit         <= 1'b0;
      disp_buf_sel   <= 1'b0;
      collision_seen <= 1'b0;
      overrun_cnt    <= 8'd0;
      frame_cnt      <= 16'd0;
    end else begin
      state          <= state_n;
      vsync_q        <= vsync;
      substep_cnt    <= substep_n;
      settle_cnt     <= settle_n;
      integ_start    <= integ_start_n;
      integ_sel      <= integ_sel_n;
      res_start      <= res_start_n;
      commit         <= commit_n;
      disp_buf_sel   <= disp_n;
      collision_seen <= coll_n;
      overrun_cnt    <= overrun_n;
      frame_cnt      <= frame_n;
    end
  end

endmodule
